sd_spi_responder: RTL and testbench
===================================

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter DEPTH, default 16: number of 64-bit blocks held; block index = addr[log2(DEPTH)-1:0].
REQ-002 Parameter NCR, default 2: MISO-high cycles between command end bit and first R1 bit.
REQ-003 Parameter NAC, default 4: MISO-high cycles between R1 last bit and read start token.
REQ-004 Parameter NBUSY, default 8: MISO-low busy cycles after data response.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 MOSI  input  1  serial host-to-card line, idles high.
REQ-008 MISO  output  1  serial card-to-host line, idles high.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 cmd_err  output  1  one-cycle pulse on rejected command frame.
REQ-011 crc_err  output  1  one-cycle pulse on write-block CRC16 mismatch.

Function
REQ-012 FSM states SHALL be: IDLE, CMD_RX, NCR_WAIT, R1_TX, RD_WAIT, RD_TX, WR_TOKEN, WR_RX, DRESP_TX, BUSY.
REQ-013 IDLE -> CMD_RX when MOSI samples 0; that bit is frame bit 47; 47 further bits shifted MSB first.
REQ-014 Frame valid iff bit47=0, bit46=1, index 17 or 24, arg[31:16]=0, CRC7 (poly x^7+x^3+1, init 0, over bits 47:8) matches bits 7:1, bit0=1.
REQ-015 After bit 0: NCR_WAIT for NCR cycles, then R1_TX drives 8 bits MSB first: 8'h00 if valid, 8'h04 otherwise.
REQ-016 Invalid frame: cmd_err pulses in the cycle NCR_WAIT is entered; after R1 return to IDLE; memory untouched.
REQ-017 CMD17: after R1, RD_WAIT for NAC cycles, then RD_TX drives 88 bits: 8'hFE, stored block, CRC16-CCITT (poly 0x1021, init 0) of block; then IDLE.
REQ-018 CMD24: after R1, WR_TOKEN shifts MOSI into an 8-bit window (cleared on entry); window==8'hFE moves to WR_RX.
REQ-019 WR_RX shifts exactly 80 bits: 64 data MSB first, then 16 CRC.
REQ-020 CRC match: block written on the cycle DRESP_TX is entered, response 8'h05; mismatch: no write, crc_err pulses, response 8'h0B.
REQ-021 DRESP_TX drives 8 bits MSB first, then BUSY holds MISO=0 for NBUSY cycles, then MISO=1 and IDLE.
REQ-022 MOSI ignored in NCR_WAIT, R1_TX, RD_WAIT, RD_TX, DRESP_TX, BUSY; command starting there is dropped, not queued.
REQ-023 MISO=1 in every state/cycle not explicitly driving a bit.
REQ-024 Read of a never-written block returns 64'h0.
REQ-025 CRC7 and CRC16 computed serially alongside shifting; no wide combinational CRC over stored frames.

Reset
REQ-026 rst_n low: FSM to IDLE, MISO=1, busy=0, cmd_err=0, crc_err=0, all counters and shift registers to 0, all blocks to 64'h0.
REQ-027 Reset mid-transfer aborts immediately; a partially received write SHALL NOT modify memory.

Structure
REQ-028 Shared package sd_pkg holds: CMD_READ=17, CMD_WRITE=24, START_TOKEN=8'hFE, DRESP_OK=8'h05, DRESP_CRC=8'h0B, R1_OK=8'h00, R1_ILLEGAL=8'h04, CRC polynomials, FSM state typedef.
REQ-029 One sub-module sd_serial_crc (parameterised 7/16-bit serial CRC with clear/enable) instantiated twice; memory inline.

Verification
REQ-030 CMD24 arg 0x0000_0003 correct CRC7, token, data 64'h0123_4567_89AB_CDEF, correct CRC16 -> R1 8'h00 after 2 high cycles, 8'h05, 8 busy-low cycles, block 3 updated.
REQ-031 CMD17 arg 0x0000_0003 after REQ-030 -> R1 8'h00, 4 high cycles, 8'hFE, 64'h0123_4567_89AB_CDEF, CRC16 of that word; MISO high after.
REQ-032 CMD17 with CRC7 bit flipped -> cmd_err one pulse, R1 8'h04, no data token, IDLE after 8 R1 bits.
REQ-033 CMD24 block 5 data 64'hFFFF_0000_FFFF_0000 with CRC16 LSB flipped -> crc_err pulse, response 8'h0B, then CMD17 block 5 returns 64'h0.
REQ-034 rst_n asserted at WR_RX bit 40 of write to block 1 -> MISO=1, busy=0 immediately; later CMD17 block 1 returns 64'h0.
REQ-035 CMD17 arg 0x0001_0000 (arg[31:16]≠0) -> cmd_err, R1 8'h04; MOSI toggling during R1 ignored.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants, CRC polynomials and FSM state type for the SD SPI-mode responder.
package sd_pkg;

  localparam logic [5:0]  CMD_READ    = 6'd17;
  localparam logic [5:0]  CMD_WRITE   = 6'd24;
  localparam logic [7:0]  START_TOKEN = 8'hFE;
  localparam logic [7:0]  DRESP_OK    = 8'h05;
  localparam logic [7:0]  DRESP_CRC   = 8'h0B;
  localparam logic [7:0]  R1_OK       = 8'h00;
  localparam logic [7:0]  R1_ILLEGAL  = 8'h04;

  localparam logic [6:0]  CRC7_POLY   = 7'h09;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;

  typedef enum logic [3:0] {
    IDLE,
    CMD_RX,
    NCR_WAIT,
    R1_TX,
    RD_WAIT,
    RD_TX,
    WR_TOKEN,
    WR_RX,
    DRESP_TX,
    BUSY
  } sd_state_e;

endpackage

// File: rtl/sd_serial_crc.sv
// Serial MSB-first CRC with zero init; i_clear restarts it and may coincide with i_enable
// so the first bit of a new stream is absorbed in the same cycle the old value is dropped.
module sd_serial_crc #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_data,
  output logic [WIDTH-1:0] o_crc
);

  logic [WIDTH-1:0] r_crc;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_next;
  logic             w_feedback;

  always_comb begin
    w_base     = i_clear ? '0 : r_crc;
    w_feedback = i_data ^ w_base[WIDTH-1];
    w_next     = {w_base[WIDTH-2:0], 1'b0} ^ (w_feedback ? POLY : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (i_enable) begin
      r_crc <= w_next;
    end else if (i_clear) begin
      r_crc <= '0;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: accepts CMD17/CMD24 frames and serves 64-bit blocks from
// an internal register memory, with serial CRC7 command checking and CRC16 data protection.
module sd_spi_responder
  import sd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int NCR   = 2,
  parameter int NAC   = 4,
  parameter int NBUSY = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic cmd_err,
  output logic crc_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sd_state_e   r_state;
  sd_state_e   w_nextState;

  logic [6:0]  r_cnt;
  logic [46:0] r_cmdShift;
  logic [63:0] r_dataShift;
  logic [14:0] r_crcRx;
  logic [6:0]  r_window;
  logic [7:0]  r_resp;
  logic        r_isRead;
  logic [AW-1:0] r_addr;
  logic        r_cmdErr;
  logic        r_crcErr;
  logic [63:0] r_mem [DEPTH];

  logic [47:0] w_frame;
  logic        w_frameValid;
  logic [7:0]  w_window;
  logic [15:0] w_crcRxFull;
  logic [3:0]  w_crcIdx;
  logic [6:0]  w_crc7;
  logic [15:0] w_crc16;
  logic        w_crc7Clear;
  logic        w_crc7Enable;
  logic        w_crc16Clear;
  logic        w_crc16Enable;
  logic        w_crc16Data;
  logic        w_unusedArg;

  // The current MOSI bit completes the frame, so validation happens in the same cycle as bit 0.
  assign w_frame     = {r_cmdShift, MOSI};
  assign w_window    = {r_window, MOSI};
  assign w_crcRxFull = {r_crcRx, MOSI};
  assign w_crcIdx    = 4'(r_cnt - 7'd72);
  assign w_unusedArg = ^w_frame[23:8+AW];

  assign w_frameValid = (w_frame[47] == 1'b0) && w_frame[46] &&
                        ((w_frame[45:40] == CMD_READ) || (w_frame[45:40] == CMD_WRITE)) &&
                        (w_frame[39:24] == 16'h0000) &&
                        (w_frame[7:1] == w_crc7) && w_frame[0];

  assign w_crc7Clear   = (r_state != CMD_RX);
  assign w_crc7Enable  = ((r_state == IDLE) && !MOSI) ||
                         ((r_state == CMD_RX) && (r_cnt <= 7'd39));
  assign w_crc16Clear  = !((r_state == RD_TX) || (r_state == WR_RX));
  assign w_crc16Enable = ((r_state == RD_TX) && (r_cnt >= 7'd8) && (r_cnt < 7'd72)) ||
                         ((r_state == WR_RX) && (r_cnt < 7'd64));
  assign w_crc16Data   = (r_state == RD_TX) ? r_dataShift[63] : MOSI;

  sd_serial_crc #(.WIDTH(7), .POLY(CRC7_POLY)) u_crc7 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_crc7Clear),
    .i_enable (w_crc7Enable),
    .i_data   (MOSI),
    .o_crc    (w_crc7)
  );

  sd_serial_crc #(.WIDTH(16), .POLY(CRC16_POLY)) u_crc16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_crc16Clear),
    .i_enable (w_crc16Enable),
    .i_data   (w_crc16Data),
    .o_crc    (w_crc16)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    MISO        = 1'b1;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (!MOSI) w_nextState = CMD_RX;
      end
      CMD_RX: begin
        if (r_cnt == 7'd47) w_nextState = NCR_WAIT;
      end
      NCR_WAIT: begin
        if (r_cnt == 7'(NCR - 1)) w_nextState = R1_TX;
      end
      R1_TX: begin
        MISO = r_resp[3'd7 - r_cnt[2:0]];
        if (r_cnt == 7'd7) begin
          if (r_resp != R1_OK) w_nextState = IDLE;
          else if (r_isRead)   w_nextState = RD_WAIT;
          else                 w_nextState = WR_TOKEN;
        end
      end
      RD_WAIT: begin
        if (r_cnt == 7'(NAC - 1)) w_nextState = RD_TX;
      end
      RD_TX: begin
        if (r_cnt < 7'd8)       MISO = START_TOKEN[3'd7 - r_cnt[2:0]];
        else if (r_cnt < 7'd72) MISO = r_dataShift[63];
        else                    MISO = w_crc16[4'd15 - w_crcIdx];
        if (r_cnt == 7'd87) w_nextState = IDLE;
      end
      WR_TOKEN: begin
        if (w_window == START_TOKEN) w_nextState = WR_RX;
      end
      WR_RX: begin
        if (r_cnt == 7'd79) w_nextState = DRESP_TX;
      end
      DRESP_TX: begin
        MISO = r_resp[3'd7 - r_cnt[2:0]];
        if (r_cnt == 7'd7) w_nextState = BUSY;
      end
      BUSY: begin
        MISO = 1'b0;
        if (r_cnt == 7'(NBUSY - 1)) w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: the counter restarts on every state change (CMD_RX starts at 1, as bit 47 is already in).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_cmdShift  <= '0;
      r_dataShift <= '0;
      r_crcRx     <= '0;
      r_window    <= '0;
      r_resp      <= '0;
      r_isRead    <= 1'b0;
      r_addr      <= '0;
      r_cmdErr    <= 1'b0;
      r_crcErr    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_cmdErr <= 1'b0;
      r_crcErr <= 1'b0;

      if (w_nextState != r_state) begin
        r_cnt <= (w_nextState == CMD_RX) ? 7'd1 : 7'd0;
      end else if ((r_state != IDLE) && (r_state != WR_TOKEN)) begin
        r_cnt <= r_cnt + 7'd1;
      end

      case (r_state)
        IDLE: begin
          if (!MOSI) r_cmdShift <= {46'd0, MOSI};
        end
        CMD_RX: begin
          r_cmdShift <= {r_cmdShift[45:0], MOSI};
          if (r_cnt == 7'd47) begin
            r_resp   <= w_frameValid ? R1_OK : R1_ILLEGAL;
            r_cmdErr <= !w_frameValid;
            r_isRead <= (w_frame[45:40] == CMD_READ);
            r_addr   <= w_frame[8 +: AW];
          end
        end
        R1_TX: begin
          if (r_cnt == 7'd7) begin
            r_window <= '0;
            if (r_isRead) r_dataShift <= r_mem[r_addr];
          end
        end
        RD_TX: begin
          if ((r_cnt >= 7'd8) && (r_cnt < 7'd72)) r_dataShift <= {r_dataShift[62:0], 1'b0};
        end
        WR_TOKEN: begin
          r_window <= w_window[6:0];
        end
        WR_RX: begin
          if (r_cnt < 7'd64) r_dataShift <= {r_dataShift[62:0], MOSI};
          else               r_crcRx     <= w_crcRxFull[14:0];
          if (r_cnt == 7'd79) begin
            if (w_crcRxFull == w_crc16) begin
              r_mem[r_addr] <= r_dataShift;
              r_resp        <= DRESP_OK;
            end else begin
              r_crcErr <= 1'b1;
              r_resp   <= DRESP_CRC;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cmd_err = r_cmdErr;
  assign crc_err = r_crcErr;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed self-checking bench for sd_spi_responder; CRCs come from a polynomial long-division model.
module tb_sd_spi_responder;

  logic clk = 1'b0;
  logic rst_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic cmd_err;
  logic crc_err;

  int checks = 0;
  int errors = 0;

  logic [87:0] cap;
  logic [87:0] capA;
  logic [87:0] capB;
  logic [63:0] dataA;
  logic [63:0] dataB;
  logic [63:0] dataC;

  always #5 clk = ~clk;

  sd_spi_responder #(.DEPTH(16), .NCR(2), .NAC(4), .NBUSY(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .busy    (busy),
    .cmd_err (cmd_err),
    .crc_err (crc_err)
  );

  function automatic logic [6:0] refCrc7(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [15:0] refCrc16(input logic [63:0] msg);
    logic [79:0] v;
    v = {msg, 16'b0};
    for (int i = 79; i >= 16; i--) if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h11021;
    return v[15:0];
  endfunction

  function automatic logic [47:0] mkFrame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] head;
    head = {2'b01, idx, arg};
    return {head, refCrc7(head), 1'b1};
  endfunction

  // Drives n bits MSB first, one per cycle, then returns MOSI to idle-high one cycle later.
  task automatic applyStimulus(input logic [87:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      MOSI = bits[i];
    end
    @(negedge clk);
    MOSI = 1'b1;
  endtask

  task automatic captureMiso(input int n, input logic toggle, output logic [87:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      if (toggle) MOSI = i[0];
      bits = {bits[86:0], MISO};
      @(negedge clk);
    end
    MOSI = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [87:0] observed, input logic [87:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, 88'(observed), 88'(expected));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dataA = 64'h0123_4567_89AB_CDEF;
    dataB = 64'hFFFF_0000_FFFF_0000;
    dataC = 64'hDEAD_BEEF_CAFE_F00D;
    rst_n = 1'b0;
    MOSI  = 1'b1;
    repeat (3) @(negedge clk);
    checkBit("reset_miso", MISO, 1'b1);
    checkBit("reset_busy", busy, 1'b0);
    checkBit("reset_cmd_err", cmd_err, 1'b0);
    checkBit("reset_crc_err", crc_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good write of block 3.
    applyStimulus({40'b0, mkFrame(6'd24, 32'h0000_0003)}, 48);
    checkBit("wr3_cmd_err", cmd_err, 1'b0);
    captureMiso(2, 1'b0, cap);
    checkOutput("wr3_ncr_high", cap, 88'h3);
    captureMiso(8, 1'b0, cap);
    checkOutput("wr3_r1", cap, 88'h00);
    checkBit("wr3_busy_token", busy, 1'b1);
    applyStimulus({8'hFE, dataA, refCrc16(dataA)}, 88);
    checkBit("wr3_crc_err", crc_err, 1'b0);
    captureMiso(8, 1'b0, cap);
    checkOutput("wr3_dresp", cap, 88'h05);
    captureMiso(8, 1'b0, cap);
    checkOutput("wr3_busy_low", cap, 88'h00);
    checkBit("wr3_idle_miso", MISO, 1'b1);
    checkBit("wr3_idle_busy", busy, 1'b0);

    // Read back block 3.
    applyStimulus({40'b0, mkFrame(6'd17, 32'h0000_0003)}, 48);
    checkBit("rd3_cmd_err", cmd_err, 1'b0);
    captureMiso(2, 1'b0, cap);
    checkOutput("rd3_ncr_high", cap, 88'h3);
    captureMiso(8, 1'b0, cap);
    checkOutput("rd3_r1", cap, 88'h00);
    captureMiso(4, 1'b0, cap);
    checkOutput("rd3_nac_high", cap, 88'hF);
    captureMiso(88, 1'b0, cap);
    checkOutput("rd3_data", cap, {8'hFE, dataA, refCrc16(dataA)});
    checkBit("rd3_idle_miso", MISO, 1'b1);
    checkBit("rd3_idle_busy", busy, 1'b0);

    // Read with a corrupted CRC7 bit.
    applyStimulus({40'b0, mkFrame(6'd17, 32'h0000_0003) ^ 48'h2}, 48);
    checkBit("badcrc_cmd_err_hi", cmd_err, 1'b1);
    captureMiso(1, 1'b0, capA);
    checkBit("badcrc_cmd_err_lo", cmd_err, 1'b0);
    captureMiso(1, 1'b0, capB);
    checkOutput("badcrc_ncr_high", 88'({capA[0], capB[0]}), 88'h3);
    captureMiso(8, 1'b0, cap);
    checkOutput("badcrc_r1", cap, 88'h04);
    checkBit("badcrc_idle_busy", busy, 1'b0);
    captureMiso(16, 1'b0, cap);
    checkOutput("badcrc_no_token", cap, 88'hFFFF);

    // Write block 5 with a bad CRC16, then confirm it stayed zero.
    applyStimulus({40'b0, mkFrame(6'd24, 32'h0000_0005)}, 48);
    captureMiso(10, 1'b0, cap);
    checkOutput("wr5_ncr_r1", cap, 88'h300);
    applyStimulus({8'hFE, dataB, refCrc16(dataB) ^ 16'h0001}, 88);
    checkBit("wr5_crc_err_hi", crc_err, 1'b1);
    captureMiso(1, 1'b0, capA);
    checkBit("wr5_crc_err_lo", crc_err, 1'b0);
    captureMiso(7, 1'b0, capB);
    checkOutput("wr5_dresp", 88'({capA[0], capB[6:0]}), 88'h0B);
    captureMiso(8, 1'b0, cap);
    checkOutput("wr5_busy_low", cap, 88'h00);
    applyStimulus({40'b0, mkFrame(6'd17, 32'h0000_0005)}, 48);
    captureMiso(14, 1'b0, cap);
    checkOutput("rd5_ncr_r1_nac", cap, 88'h300F);
    captureMiso(88, 1'b0, cap);
    checkOutput("rd5_data", cap, {8'hFE, 64'h0, 16'h0});

    // Reset in the middle of a write to block 1.
    applyStimulus({40'b0, mkFrame(6'd24, 32'h0000_0001)}, 48);
    captureMiso(10, 1'b0, cap);
    checkOutput("wr1_ncr_r1", cap, 88'h300);
    applyStimulus({40'b0, 8'hFE, dataC[63:24]}, 48);
    checkBit("wr1_busy_mid", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    checkBit("wr1_reset_miso", MISO, 1'b1);
    checkBit("wr1_reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus({40'b0, mkFrame(6'd17, 32'h0000_0001)}, 48);
    captureMiso(14, 1'b0, cap);
    checkOutput("rd1_ncr_r1_nac", cap, 88'h300F);
    captureMiso(88, 1'b0, cap);
    checkOutput("rd1_data", cap, {8'hFE, 64'h0, 16'h0});

    // Nonzero upper argument, with MOSI toggling through the response.
    applyStimulus({40'b0, mkFrame(6'd17, 32'h0001_0000)}, 48);
    checkBit("badarg_cmd_err", cmd_err, 1'b1);
    captureMiso(10, 1'b1, cap);
    checkOutput("badarg_ncr_r1", cap, 88'h304);
    checkBit("badarg_idle_busy", busy, 1'b0);
    captureMiso(4, 1'b0, cap);
    checkOutput("badarg_idle_miso", cap, 88'hF);
    checkBit("badarg_still_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
